// File: rtl/bs_tap_controller.sv
// IEEE 1149.1 TAP controller: 16-state TAP FSM, instruction register,
// BYPASS and IDCODE data registers, and boundary-scan chain strobes.
// Single clock domain; ClockBR/UpdateBR are one-cycle enables, not clocks.
module bs_tap_controller #(
    parameter int                  IRLength    = 4,
    parameter logic [IRLength-1:0] ExtestCode  = 4'b0000,
    parameter logic [IRLength-1:0] SampleCode  = 4'b0001,
    parameter logic [IRLength-1:0] IdcodeCode  = 4'b0010,
    parameter logic [IRLength-1:0] BypassCode  = 4'b1111,
    parameter logic [31:0]         IdcodeValue = 32'h1000_0001
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                TMS,
    input  logic                TDI,
    output logic                TDO,
    output logic                TDOEnable,
    output logic                BSR_SIN,
    input  logic                BSR_SOUT,
    output logic                ShiftBR,
    output logic                ClockBR,
    output logic                UpdateBR,
    output logic                ModeControl,
    output logic                BSRRstBar,
    output logic [3:0]          TapState,
    output logic [IRLength-1:0] ActiveInstr
);

    typedef enum logic [3:0] {
        TLR     = 4'hF, RTI     = 4'hC,
        SEL_DR  = 4'h7, CAP_DR  = 4'h6, SH_DR   = 4'h2, EX1_DR  = 4'h1,
        PAUS_DR = 4'h3, EX2_DR  = 4'h0, UPD_DR  = 4'h5,
        SEL_IR  = 4'h4, CAP_IR  = 4'hE, SH_IR   = 4'hA, EX1_IR  = 4'h9,
        PAUS_IR = 4'hB, EX2_IR  = 4'h8, UPD_IR  = 4'hD
    } tap_state_e;

    tap_state_e          state_q, state_d;
    logic [IRLength-1:0] ir_q, ir_d;
    logic [IRLength-1:0] act_q, act_d;
    logic                mode_q, mode_d;
    logic                byp_q, byp_d;
    logic [31:0]         id_q, id_d;

    logic sel_bsr_s;
    logic sel_id_s;
    logic tdo_s, tdo_en_s, shift_br_s, clock_br_s, update_br_s;

    // BypassCode and any undefined opcode fall through to the BYPASS register.
    assign sel_bsr_s = (act_q == ExtestCode) || (act_q == SampleCode);
    assign sel_id_s  = (act_q == IdcodeCode) && (act_q != BypassCode);

    // TAP state transition table driven by TMS.
    always_comb begin
        state_d = TLR;
        case (state_q)
            TLR:     state_d = TMS ? TLR    : RTI;
            RTI:     state_d = TMS ? SEL_DR : RTI;
            SEL_DR:  state_d = TMS ? SEL_IR : CAP_DR;
            CAP_DR:  state_d = TMS ? EX1_DR : SH_DR;
            SH_DR:   state_d = TMS ? EX1_DR : SH_DR;
            EX1_DR:  state_d = TMS ? UPD_DR : PAUS_DR;
            PAUS_DR: state_d = TMS ? EX2_DR : PAUS_DR;
            EX2_DR:  state_d = TMS ? UPD_DR : SH_DR;
            UPD_DR:  state_d = TMS ? SEL_DR : RTI;
            SEL_IR:  state_d = TMS ? TLR    : CAP_IR;
            CAP_IR:  state_d = TMS ? EX1_IR : SH_IR;
            SH_IR:   state_d = TMS ? EX1_IR : SH_IR;
            EX1_IR:  state_d = TMS ? UPD_IR : PAUS_IR;
            PAUS_IR: state_d = TMS ? EX2_IR : PAUS_IR;
            EX2_IR:  state_d = TMS ? UPD_IR : SH_IR;
            UPD_IR:  state_d = TMS ? SEL_DR : RTI;
            default: state_d = TLR;
        endcase
    end

    // Register datapath: actions happen on the edge that leaves each state.
    always_comb begin
        ir_d   = ir_q;
        act_d  = act_q;
        mode_d = mode_q;
        byp_d  = byp_q;
        id_d   = id_q;
        case (state_q)
            CAP_IR: ir_d = {{(IRLength-2){1'b0}}, 2'b01};
            SH_IR:  ir_d = {TDI, ir_q[IRLength-1:1]};
            UPD_IR: begin
                act_d  = ir_q;
                mode_d = (ir_q == ExtestCode);
            end
            CAP_DR: begin
                byp_d = 1'b0;
                id_d  = IdcodeValue;
            end
            SH_DR: begin
                if (sel_bsr_s) begin
                    byp_d = byp_q;
                end else if (sel_id_s) begin
                    id_d = {TDI, id_q[31:1]};
                end else begin
                    byp_d = TDI;
                end
            end
            default: ;
        endcase
        // Entering Test-Logic-Reset restores the power-on instruction.
        if (state_d == TLR) begin
            ir_d   = IdcodeCode;
            act_d  = IdcodeCode;
            mode_d = 1'b0;
            byp_d  = 1'b0;
        end else begin
            mode_d = mode_d;
        end
    end

    // State and register update with synchronous reset to TLR.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= TLR;
            ir_q    <= IdcodeCode;
            act_q   <= IdcodeCode;
            mode_q  <= 1'b0;
            byp_q   <= 1'b0;
            id_q    <= IdcodeValue;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            act_q   <= act_d;
            mode_q  <= mode_d;
            byp_q   <= byp_d;
            id_q    <= id_d;
        end
    end

    // Serial output mux and BSR strobes decoded from the current state.
    always_comb begin
        tdo_s       = 1'b0;
        tdo_en_s    = 1'b0;
        shift_br_s  = 1'b0;
        clock_br_s  = 1'b0;
        update_br_s = 1'b0;
        case (state_q)
            SH_IR: begin
                tdo_en_s = 1'b1;
                tdo_s    = ir_q[0];
            end
            SH_DR: begin
                tdo_en_s   = 1'b1;
                tdo_s      = sel_bsr_s ? BSR_SOUT : (sel_id_s ? id_q[0] : byp_q);
                shift_br_s = sel_bsr_s;
                clock_br_s = sel_bsr_s;
            end
            CAP_DR:  clock_br_s  = sel_bsr_s;
            UPD_DR:  update_br_s = sel_bsr_s;
            default: ;
        endcase
    end

    assign TDO         = tdo_s;
    assign TDOEnable   = tdo_en_s;
    assign BSR_SIN     = TDI;
    assign ShiftBR     = shift_br_s;
    assign ClockBR     = clock_br_s;
    assign UpdateBR    = update_br_s;
    assign ModeControl = mode_q;
    assign BSRRstBar   = (state_q != TLR);
    assign TapState    = state_q;
    assign ActiveInstr = act_q;

endmodule

// File: tb/tb_bs_tap_controller.sv
// Bench for bs_tap_controller: table-driven TAP model checked every cycle,
// directed scans with literal expectations, then randomized TMS/TDI traffic.
module tb_bs_tap_controller;

    localparam int          IRL = 4;
    localparam logic [31:0] IDV = 32'h1000_0001;

    localparam int S_EX2DR = 0,  S_EX1DR = 1,  S_SHDR = 2,  S_PDR = 3;
    localparam int S_SELIR = 4,  S_UPDDR = 5,  S_CAPDR = 6, S_SELDR = 7;
    localparam int S_EX2IR = 8,  S_EX1IR = 9,  S_SHIR = 10, S_PIR = 11;
    localparam int S_RTI = 12,   S_UPDIR = 13, S_CAPIR = 14, S_TLR = 15;

    // next state indexed by TapState encoding, for TMS=0 and TMS=1
    int nx0 [16] = '{2, 3, 2, 3, 14, 12, 2, 6, 10, 11, 10, 11, 12, 12, 10, 12};
    int nx1 [16] = '{5, 5, 1, 0, 15, 7, 1, 4, 13, 13, 9, 8, 7, 7, 9, 15};

    logic           Clock = 1'b0;
    logic           Reset = 1'b1, TMS = 1'b0, TDI = 1'b0, BSR_SOUT = 1'b0;
    logic           TDO, TDOEnable, BSR_SIN, ShiftBR, ClockBR, UpdateBR;
    logic           ModeControl, BSRRstBar;
    logic [3:0]     TapState;
    logic [IRL-1:0] ActiveInstr;

    int n_checks = 0;
    int n_pass   = 0;
    bit check_en = 1'b0;

    // behavioural model
    int          m_st  = S_TLR;
    logic [3:0]  m_ir  = 4'd2;
    logic [3:0]  m_act = 4'd2;
    logic        m_byp = 1'b0;
    logic [31:0] m_id  = IDV;

    // per-cycle samples taken mid-cycle by drive()
    logic tdo_s, clk_s, upd_s, sh_s;
    int   clk_cnt, upd_cnt, sh_cnt, mirror_err;
    logic [3:0]  cap_bits;
    logic [31:0] word;
    logic        mc_in_upd, mc_after;
    logic [7:0]  dr_tdo;

    bs_tap_controller dut (
        .Clock(Clock), .Reset(Reset), .TMS(TMS), .TDI(TDI), .TDO(TDO),
        .TDOEnable(TDOEnable), .BSR_SIN(BSR_SIN), .BSR_SOUT(BSR_SOUT),
        .ShiftBR(ShiftBR), .ClockBR(ClockBR), .UpdateBR(UpdateBR),
        .ModeControl(ModeControl), .BSRRstBar(BSRRstBar),
        .TapState(TapState), .ActiveInstr(ActiveInstr)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic bit is_bsr(input logic [3:0] a);
        return (a == 4'b0000) || (a == 4'b0001);
    endfunction

    function automatic bit is_id(input logic [3:0] a);
        return a == 4'b0010;
    endfunction

    task automatic model_step(input logic r, input logic t, input logic d);
        int nst;
        if (r) begin
            m_st = S_TLR; m_ir = 4'd2; m_act = 4'd2; m_byp = 1'b0; m_id = IDV;
        end else begin
            nst = t ? nx1[m_st] : nx0[m_st];
            if (m_st == S_CAPIR) m_ir = 4'b0001;
            else if (m_st == S_SHIR) m_ir = (m_ir >> 1) | (IRL'(d) << (IRL - 1));
            else if (m_st == S_UPDIR) m_act = m_ir;
            else if (m_st == S_CAPDR) begin m_byp = 1'b0; m_id = IDV; end
            else if (m_st == S_SHDR) begin
                if (is_id(m_act)) m_id = (m_id >> 1) | (32'(d) << 31);
                else if (!is_bsr(m_act)) m_byp = d;
            end
            m_st = nst;
            if (m_st == S_TLR) begin m_ir = 4'd2; m_act = 4'd2; m_byp = 1'b0; end
        end
    endtask

    // apply inputs for one cycle, sample mid-cycle, clock, advance the model
    task automatic drive(input logic r, input logic t, input logic d, input logic s);
        Reset = r; TMS = t; TDI = d; BSR_SOUT = s;
        #2;
        tdo_s = TDO; clk_s = ClockBR; upd_s = UpdateBR; sh_s = ShiftBR;
        clk_cnt += int'(clk_s); upd_cnt += int'(upd_s); sh_cnt += int'(sh_s);
        @(posedge Clock);
        model_step(r, t, d);
        #1;
    endtask

    task automatic clr_cnt();
        clk_cnt = 0; upd_cnt = 0; sh_cnt = 0; mirror_err = 0;
    endtask

    // IR scan from RTI, ends in RTI
    task automatic ir_scan(input logic [3:0] op);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < IRL; i++) begin
            drive(1'b0, (i == IRL - 1), op[i], 1'b0);
            cap_bits[i] = tdo_s;
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        mc_in_upd = ModeControl;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        mc_after = ModeControl;
    endtask

    // DR scan of n bits from RTI, ends in RTI
    task automatic dr_scan(input int n, input logic [7:0] bits);
        logic s;
        clr_cnt();
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            s = 1'($urandom_range(0, 1));
            drive(1'b0, (i == n - 1), bits[i], s);
            dr_tdo[i] = tdo_s;
            if (tdo_s !== s) mirror_err++;
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // 4-bit DR scan with an Exit1/Pause x3/Exit2 excursion after bit 1
    int pause_clk;
    task automatic dr_pause_scan(input logic [3:0] bits);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, bits[0], 1'b0); dr_tdo[0] = tdo_s;
        drive(1'b0, 1'b1, bits[1], 1'b0); dr_tdo[1] = tdo_s;
        clk_cnt = 0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        pause_clk = clk_cnt;
        drive(1'b0, 1'b0, bits[2], 1'b0); dr_tdo[2] = tdo_s;
        drive(1'b0, 1'b1, bits[3], 1'b0); dr_tdo[3] = tdo_s;
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // every-cycle comparison against the model
    logic e_tdo;
    always @(negedge Clock) begin
        if (check_en) begin
            if (m_st == S_SHIR) e_tdo = m_ir[0];
            else if (m_st == S_SHDR)
                e_tdo = is_bsr(m_act) ? BSR_SOUT : (is_id(m_act) ? m_id[0] : m_byp);
            else e_tdo = 1'b0;
            check("TapState",    32'(TapState),    32'(m_st));
            check("ActiveInstr", 32'(ActiveInstr), 32'(m_act));
            check("TDO",         32'(TDO),         32'(e_tdo));
            check("TDOEnable",   32'(TDOEnable),   32'((m_st == S_SHIR) || (m_st == S_SHDR)));
            check("ShiftBR",     32'(ShiftBR),     32'(is_bsr(m_act) && m_st == S_SHDR));
            check("ClockBR",     32'(ClockBR),     32'(is_bsr(m_act) && (m_st == S_SHDR || m_st == S_CAPDR)));
            check("UpdateBR",    32'(UpdateBR),    32'(is_bsr(m_act) && m_st == S_UPDDR));
            check("ModeControl", 32'(ModeControl), 32'(m_act == 4'b0000));
            check("BSRRstBar",   32'(BSRRstBar),   32'(m_st != S_TLR));
            check("BSR_SIN",     32'(BSR_SIN),     32'(TDI));
        end
    end

    initial begin
        clr_cnt();
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        check_en = 1'b1;
        check("rst_state", 32'(TapState), 32'hF);
        check("rst_instr", 32'(ActiveInstr), 32'h2);
        check("rst_bsrrst", 32'(BSRRstBar), 32'h0);
        check("rst_mode", 32'(ModeControl), 32'h0);

        // IDCODE readout
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("at_shdr", 32'(TapState), 32'h2);
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0);
            word[i] = tdo_s;
        end
        check("idcode_word", word, 32'h1000_0001);
        check("idcode_instr", 32'(ActiveInstr), 32'h2);

        // five TMS=1 from mid-shift reach TLR with no update strobe
        clr_cnt();
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 1'b1, 1'b1);
        check("tms5_state", 32'(TapState), 32'hF);
        check("tms5_bsrrst", 32'(BSRRstBar), 32'h0);
        check("tms5_noupd", 32'(upd_cnt), 32'h0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);

        // BYPASS opcode and 1-cycle delay
        ir_scan(4'b1111);
        check("ir_cap0", 32'(cap_bits[0]), 32'h1);
        check("ir_cap1", 32'(cap_bits[1]), 32'h0);
        check("byp_instr", 32'(ActiveInstr), 32'hF);
        dr_scan(3, 8'b0000_0101);
        check("byp_tdo", 32'(dr_tdo[2:0]), 32'b010);
        check("byp_noclk", 32'(clk_cnt), 32'h0);

        // EXTEST: mode switch on UpdIR edge and BSR strobes
        ir_scan(4'b0000);
        check("ext_mc_upd", 32'(mc_in_upd), 32'h0);
        check("ext_mc_after", 32'(mc_after), 32'h1);
        dr_scan(5, 8'h1B);
        check("ext_clk", 32'(clk_cnt), 32'd6);
        check("ext_shift", 32'(sh_cnt), 32'd5);
        check("ext_upd", 32'(upd_cnt), 32'd1);
        check("ext_mirror", 32'(mirror_err), 32'h0);
        dr_pause_scan(4'b1010);
        check("ext_pause_clk", 32'(pause_clk), 32'h0);

        // reset mid-scan under EXTEST aborts without UpdateBR
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        clr_cnt();
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("rstmid_noupd", 32'(upd_cnt), 32'h0);
        check("rstmid_instr", 32'(ActiveInstr), 32'h2);
        check("rstmid_mode", 32'(ModeControl), 32'h0);

        // IDCODE data survives a pause excursion
        dr_pause_scan(4'b0110);
        check("pause_idbits", 32'(dr_tdo[3:0]), 32'b0001);

        // undefined opcode behaves as BYPASS
        ir_scan(4'b0110);
        check("undef_instr", 32'(ActiveInstr), 32'h6);
        check("undef_mode", 32'(ModeControl), 32'h0);
        dr_scan(3, 8'b0000_0101);
        check("undef_tdo", 32'(dr_tdo[2:0]), 32'b010);
        check("undef_nostrobe", 32'(clk_cnt + upd_cnt + sh_cnt), 32'h0);

        // randomized traffic, occasional resets
        for (int i = 0; i < 3000; i++)
            drive(($urandom_range(0, 199) == 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        @(negedge Clock);
        check_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bs_tap_controller.md
Name: bs_tap_controller

Overview:
- IEEE 1149.1 TAP controller that sequences the boundary-scan register chain (BSR) and owns the instruction register (IR), the BYPASS register and the IDCODE register.
- Decodes TMS into the 16-state TAP FSM and produces the chain controls ShiftBR, ClockBR, UpdateBR and ModeControl.
- Multiplexes the serial output of the selected register onto TDO.
- Single-clock design: ClockBR and UpdateBR are one-cycle enable strobes in the Clock domain, not derived clocks.

Parameters:
IRLength, 4, IR width (>=2)
ExtestCode, 4'b0000, EXTEST opcode
SampleCode, 4'b0001, SAMPLE/PRELOAD opcode
IdcodeCode, 4'b0010, IDCODE opcode
BypassCode, 4'b1111, BYPASS opcode
IdcodeValue, 32'h1000_0001, device ID word (bit0 must be 1)

Ports:
Clock  in  1  TAP clock (TCK equivalent), rising-edge
Reset  in  1  synchronous, active-high; forces Test-Logic-Reset (TLR)
TMS  in  1  test mode select, sampled on rising edge
TDI  in  1  serial test data in
TDO  out  1  serial test data out
TDOEnable  out  1  high only in Shift-IR / Shift-DR
BSR_SIN  out  1  serial in to the BSR chain (= TDI)
BSR_SOUT  in  1  serial out of the BSR chain
ShiftBR  out  1  BSR shift select (1 = shift, 0 = capture)
ClockBR  out  1  BSR capture/shift enable strobe
UpdateBR  out  1  BSR update strobe
ModeControl  out  1  BSR output mux select (1 = drive test data)
BSRRstBar  out  1  active-low reset to the BSR chain
TapState  out  4  current FSM state encoding
ActiveInstr  out  IRLength  current instruction

Behaviour:
- State encoding (TapState):
  - TLR=F, RTI=C, SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PauseDR=3, Ex2DR=0, UpdDR=5
  - SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PauseIR=B, Ex2IR=8, UpdIR=D
- Transitions: standard 1149.1 table on TMS at each rising edge.
  - TLR: 0→RTI. RTI: 1→SelDR. SelDR: 0→CapDR, 1→SelIR. SelIR: 0→CapIR, 1→TLR.
  - Cap*: 0→Sh*, 1→Ex1*. Sh*: 1→Ex1*. Ex1*: 0→Pause*, 1→Upd*. Pause*: 1→Ex2*. Ex2*: 0→Sh*, 1→Upd*.
  - Upd*: 0→RTI, 1→SelDR.
  - Five consecutive TMS=1 reach TLR from any state.
- Reset (sync) or being in TLR:
  - State=TLR; ActiveInstr=IdcodeCode; IR shift reg=IdcodeCode; BYPASS=0.
  - ModeControl=0; BSRRstBar=0.
  - ShiftBR, ClockBR, UpdateBR, TDO, TDOEnable all 0.
- BSRRstBar=0 while in TLR, otherwise 1.
- Reset asserted mid-scan aborts the scan with no update strobe; ActiveInstr reloads to IdcodeCode.
- IR path (registered on the edge that leaves the state):
  - CapIR: IR shift reg loads {0…0,2'b01}.
  - ShIR: shift right, TDI into MSB.
  - UpdIR: ActiveInstr <= IR shift reg.
- Opcode decode: any opcode other than the four defined decodes as BYPASS.
- DR select from ActiveInstr:
  - EXTEST, SAMPLE → BSR
  - IDCODE → 32-bit ID reg
  - else → BYPASS
- CapDR:
  - BYPASS reg <= 0.
  - ID reg <= IdcodeValue.
- ShDR:
  - selected register shifts right, TDI into MSB.
  - BYPASS is 1 bit: TDI→reg, reg→TDO, giving exactly 1-cycle delay.
- BSR strobes (combinational from state, only when BSR selected):
  - ClockBR=1 in CapDR and ShDR.
  - ShiftBR=1 in ShDR, 0 otherwise.
  - UpdateBR=1 in UpdDR.
  - Exactly one UpdateBR cycle per Update-DR visit.
  - Pause and Exit states: no strobes, registers hold.
- ModeControl=1 iff ActiveInstr decodes to EXTEST.
  - Changes on the UpdIR edge, not during the IR shift.
- TDO (combinational), 0 outside shift states:
  - ShIR: IR shift reg[0].
  - ShDR: LSB of selected DR, or BSR_SOUT when BSR is selected.
- A 1-bit IR shift count or IR length mismatch is not detected; whatever lands in the register is what gets updated.

Test Plan:
- Reset, then TMS 0,1,0,0 to ShDR; shift 32 cycles with TDI=0 → TDO stream LSB-first = 0x10000001; ActiveInstr=4'b0010.
- From ShDR (mid-shift), apply TMS=1 for 5 cycles → TapState=F on 5th edge, BSRRstBar=0, no UpdateBR pulse.
- IR scan shifting 4'b1111 → TDO on the first two shift cycles = 1,0 (capture pattern); after UpdIR, ActiveInstr=4'b1111. A following DR shift of TDI 1,0,1 → TDO 0,1,0 (1-cycle delay).
- Load EXTEST, then DR scan → ModeControl rises on the UpdIR edge.
  - ClockBR high in CapDR and every ShDR cycle; ShiftBR high only in ShDR.
  - UpdateBR high exactly 1 cycle in UpdDR; TDO mirrors BSR_SOUT.
- Load opcode 4'b0110 (undefined) → BYPASS behaviour, ModeControl=0, no BSR strobes.
- DR scan with a PauseDR excursion (Ex1→Pause ×3→Ex2→ShDR) → shifted data intact, ClockBR low during the pause.
